// File: rtl/trace_mon.sv
// Multi-channel trace monitor: round-robin capture into a FIFO, host-write / cycle-limit halt.
// Optional per-entry timestamp output (out_time) enabled by defining TRACE_MON_TIMESTAMP_EN.
module trace_mon #(
  parameter  int unsigned CHANNELS = 4,
  parameter  int unsigned DEPTH    = 16,
  localparam int unsigned CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [CHANNELS-1:0]      trc_valid,
  output logic [CHANNELS-1:0]      trc_ready,
  input  logic [CHANNELS*32-1:0]   trc_pc,
  input  logic [CHANNELS*32-1:0]   trc_addr,
  input  logic [CHANNELS*32-1:0]   trc_data,
  input  logic [CHANNELS-1:0]      chan_en,
  input  logic [31:0]              stoptime,
  input  logic [31:0]              host_addr,
  input  logic                     mem_valid,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  input  logic [3:0]               mem_wstrb,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CW-1:0]            out_chan,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_addr,
  output logic [31:0]              out_data,
  output logic                     done,
  output logic                     timeout,
  output logic [31:0]              exit_code,
  output logic [31:0]              cycles
`ifdef TRACE_MON_TIMESTAMP_EN
  ,
  output logic [31:0]              out_time
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  state_t            r_state, w_state_n;
  logic [CW-1:0]     r_last;
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [AW:0]       r_count;
  logic [31:0]       r_cycles, r_exit_code;
  logic              r_timeout;

  logic [CW-1:0]     r_mem_chan [DEPTH];
  logic [31:0]       r_mem_pc   [DEPTH];
  logic [31:0]       r_mem_addr [DEPTH];
  logic [31:0]       r_mem_data [DEPTH];
`ifdef TRACE_MON_TIMESTAMP_EN
  logic [31:0]       r_mem_time [DEPTH];
`endif

  logic [CHANNELS-1:0] w_req, w_grant;
  logic [CW-1:0]       w_gidx;
  logic                w_any;
  logic [31:0]         w_pc, w_addr, w_data;
  logic                w_full, w_empty, w_run, w_push, w_pop;
  logic                w_host_wr, w_tmo_hit;
  logic                w_unused_bits;

  assign w_req   = trc_valid & chan_en;
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_run   = (r_state == RUN);

  // Search starts one past the last granted channel, wrapping back to it.
  always_comb begin
    int unsigned idx;
    w_grant = '0;
    w_gidx  = r_last;
    w_any   = 1'b0;
    w_pc    = '0;
    w_addr  = '0;
    w_data  = '0;
    idx     = 0;
    for (int unsigned k = 1; k <= CHANNELS; k++) begin
      idx = (32'(r_last) + k) % CHANNELS;
      if (!w_any && w_req[idx[CW-1:0]]) begin
        w_any                = 1'b1;
        w_gidx               = idx[CW-1:0];
        w_grant[idx[CW-1:0]] = 1'b1;
        w_pc                 = trc_pc[32*idx +: 32];
        w_addr               = trc_addr[32*idx +: 32];
        w_data               = trc_data[32*idx +: 32];
      end
    end
  end

  // Disabled channels are always acknowledged while running so their events drop on the floor.
  assign trc_ready = w_run ? ((w_grant & {CHANNELS{~w_full}}) | ~chan_en) : '0;

  assign w_push    = w_run & w_any & ~w_full;
  assign w_pop     = ~w_empty & out_ready;

  assign w_host_wr = mem_valid & (mem_addr[31:2] == host_addr[31:2]) & (|mem_wstrb);
  assign w_tmo_hit = (stoptime != '0) & (r_cycles == (stoptime - 32'd1));
  assign w_unused_bits = ^{mem_addr[1:0], host_addr[1:0]};

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      RUN:     if (w_host_wr || w_tmo_hit) w_state_n = DRAIN;
      DRAIN:   if (w_empty) w_state_n = HALT;
      HALT:    w_state_n = HALT;
      default: w_state_n = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= RUN;
      r_last      <= CW'(CHANNELS - 1);
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_cycles    <= '0;
      r_exit_code <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if (w_push) begin
        r_last <= w_gidx;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_run) begin
        if (r_cycles != '1) r_cycles <= r_cycles + 32'd1;
        if (w_host_wr)      r_exit_code <= mem_wdata;
        else if (w_tmo_hit) r_timeout   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_chan[r_wptr] <= w_gidx;
      r_mem_pc[r_wptr]   <= w_pc;
      r_mem_addr[r_wptr] <= w_addr;
      r_mem_data[r_wptr] <= w_data;
`ifdef TRACE_MON_TIMESTAMP_EN
      r_mem_time[r_wptr] <= r_cycles;
`endif
    end
  end

  assign out_valid = ~w_empty;
  assign out_chan  = r_mem_chan[r_rptr];
  assign out_pc    = r_mem_pc[r_rptr];
  assign out_addr  = r_mem_addr[r_rptr];
  assign out_data  = r_mem_data[r_rptr];
`ifdef TRACE_MON_TIMESTAMP_EN
  assign out_time  = r_mem_time[r_rptr];
`endif

  assign done      = (r_state == HALT);
  assign timeout   = r_timeout;
  assign exit_code = r_exit_code;
  assign cycles    = r_cycles;

endmodule
